mips_multicycle_ctrl: RTL

Main control FSM for the multicycle MIPS datapath. It sequences the shared ALU, register file, memory and PC across FETCH/DECODE/EXECUTE/MEM/WB steps. It drives the 3-bit alucontrol directly in the ALU's encoding, so no separate ALU-decoder block is needed. Sits between the instruction register (op/funct) and the datapath muxes and enables.

---
 rtl/mips_multicycle_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB steps and drives ALU control directly.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_SLT = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   store_q;
    logic   funct_ok;
    logic   pcen_s;
    logic   irwrite_s;
    logic   memwrite_s;
    logic   regwrite_s;
    logic   done_s;

    // ALU encoding for an R-type funct; unsupported values fall back to add
    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            FN_ADD:  alu_of = ALU_ADD;
            FN_SUB:  alu_of = ALU_SUB;
            FN_AND:  alu_of = ALU_AND;
            FN_OR:   alu_of = ALU_OR;
            FN_SLT:  alu_of = ALU_SLT;
            default: alu_of = ALU_ADD;
        endcase
    endfunction

    // Flags whether funct is one of the supported R-type operations
    always_comb begin
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                               funct_ok = 1'b0;
        endcase
    end

    // State register; op is not held stable after DECODE, so lw/sw is latched there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                store_q <= (op == OP_SW);
            end
        end
    end

    // Next-state and per-state outputs
    always_comb begin
        state_d    = FETCH;
        pcen_s     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        done_s     = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        case (state_q)
            FETCH: begin
                irwrite_s = 1'b1;
                alusrcb   = 2'b01;
                pcen_s    = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = funct_ok ? EXEC : FETCH;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = store_q ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            EXEC: begin
                alusrca    = 1'b1;
                alucontrol = alu_of(funct);
                state_d    = ALUWB;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen_s     = zero;
                done_s     = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            JUMP: begin
                pcsrc  = 2'b10;
                pcen_s = 1'b1;
                done_s = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write enables and the done pulse are suppressed for as long as reset is held
    assign pcen       = pcen_s & ~reset;
    assign irwrite    = irwrite_s & ~reset;
    assign memwrite   = memwrite_s & ~reset;
    assign regwrite   = regwrite_s & ~reset;
    assign instr_done = done_s & ~reset;
    assign state      = 4'(state_q);

endmodule
